prng_dice: RTL
==============

PRNG_DICE -- requirements
Module: prng_dice

Interface
REQ-001 Parameter ROLL_CYCLES, default 16, SHALL set the animation length in clock cycles; legal range 2..255.
REQ-002 Parameter SETTLE_MAX, default 8, SHALL set the maximum consecutive rejected samples tolerated in SETTLE; legal range 1..15.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_asyn, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-005 Port rnd_in, input, 8 bits, SHALL carry the free-running PRNG word, new value every cycle; only rnd_in[2:0] is used.
REQ-006 Port roll, input, 1 bit, SHALL request a dice roll, synchronous to clk.
REQ-007 Port busy, output, 1 bit, SHALL be high while a roll is in progress (state ROLL or SETTLE).
REQ-008 Port done, output, 1 bit, SHALL pulse high one cycle when the final face is registered.
REQ-009 Port face, output, 3 bits, SHALL hold the current face value: 0 = blank, 1..6 = die face.
REQ-010 Port seg, output, 7 bits, SHALL drive the seven-segment pattern of face, order {g,f,e,d,c,b,a}, active-high.

Function
REQ-011 Sample s = rnd_in[2:0]; s SHALL be accepted when s <= 5 (mapped face = s+1) and rejected when s = 6 or 7.
REQ-012 FSM SHALL have exactly three states: IDLE, ROLL, SETTLE.
REQ-013 IDLE: busy=0; roll=1 at a rising edge SHALL move to ROLL and clear the cycle counter to 0.
REQ-014 ROLL: each edge, an accepted s SHALL update face to s+1; a rejected s SHALL leave face unchanged.
REQ-015 ROLL: the cycle counter SHALL increment each edge; at the edge where counter = ROLL_CYCLES-1 the FSM SHALL move to SETTLE and clear the reject counter.
REQ-016 SETTLE: an accepted s SHALL load face = s+1, assert done for that one cycle, and return to IDLE.
REQ-017 SETTLE: a rejected s SHALL increment the reject counter; at the SETTLE_MAX-th consecutive reject the block SHALL force face = s-5 (6->1, 7->2), assert done, and return to IDLE.
REQ-018 done SHALL be registered, high for exactly one cycle, and coincident with the first cycle face shows the final value with state IDLE.
REQ-019 Latency from the roll-sampling edge to done high SHALL be ROLL_CYCLES+1 cycles minimum and ROLL_CYCLES+SETTLE_MAX cycles maximum.
REQ-020 roll asserted while busy=1 SHALL be ignored, with no queuing; roll held high continuously SHALL start a new roll on the edge after done.
REQ-021 roll=1 on the same edge that done is asserted SHALL be ignored, because the FSM is not yet in IDLE at that edge.
REQ-022 seg SHALL be a combinational decode of face: 0->0x00, 1->0x06, 2->0x5B, 3->0x4F, 4->0x66, 5->0x6D, 6->0x7D; face 7 is unreachable and SHALL decode to 0x00.
REQ-023 face SHALL never hold 7 under any input sequence.

Reset
REQ-024 rst_asyn high SHALL immediately, without waiting for a clk edge, force state=IDLE, face=0, seg=0x00, busy=0, done=0, and clear both counters.
REQ-025 rst_asyn asserted mid-roll SHALL abort the roll without a done pulse; after release, the first roll behaves as from power-up.
REQ-026 Deassertion of rst_asyn SHALL take effect at the next rising clk edge; roll sampled on that edge is honoured.

Verification
REQ-027 Reset: assert rst_asyn between clock edges -> face=0, seg=0x00, busy=0, done=0 before the next edge.
REQ-028 Normal roll (ROLL_CYCLES=16): rnd_in[2:0] cycling 0..5, pulse roll one cycle -> busy high for 17 cycles, done on cycle 17, face = (s at that edge)+1, seg matches REQ-022.
REQ-029 Rejection: hold rnd_in[2:0]=7 throughout the roll -> face stays 0 during ROLL, done after exactly 16+8 cycles, face=2, seg=0x5B.
REQ-030 Late accept: rnd_in[2:0]=6 for the first 3 SETTLE cycles, then 3 -> done on the 4th SETTLE cycle, face=4, seg=0x66.
REQ-031 Busy ignore: second roll pulse mid-ROLL, plus roll high on the done edge -> exactly one done pulse, busy low the cycle after done.
REQ-032 Mid-roll reset: rst_asyn pulse at ROLL cycle 5 -> no done, face=0; a subsequent roll completes normally in 17 cycles.

Source files
------------

// File: rtl/prng_dice.sv
// Electronic die: animates random faces for ROLL_CYCLES clocks, then settles on
// an unbiased face using rejection sampling of rnd_in[2:0].
`timescale 1ns/1ps
module prng_dice #(
    parameter int unsigned ROLL_CYCLES = 16,
    parameter int unsigned SETTLE_MAX  = 8
) (
    input  logic       clk,
    input  logic       rst_asyn,
    input  logic [7:0] rnd_in,
    input  logic       roll,
    output logic       busy,
    output logic       done,
    output logic [2:0] face,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROLL,
        ST_SETTLE
    } state_t;

    localparam logic [7:0] LP_CYC_LAST = 8'(ROLL_CYCLES - 1);
    localparam logic [3:0] LP_REJ_LAST = 4'(SETTLE_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cyc_cnt;
    logic [7:0] w_cyc_cnt_nxt;
    logic [3:0] r_rej_cnt;
    logic [3:0] w_rej_cnt_nxt;
    logic [2:0] r_face;
    logic [2:0] w_face_nxt;
    logic       r_done;
    logic       w_done_nxt;

    logic [2:0] w_s;
    logic       w_accept;
    logic [2:0] w_face_acc;
    logic [2:0] w_face_force;
    logic       w_unused_rnd;

    assign w_s          = rnd_in[2:0];
    assign w_accept     = (w_s <= 3'd5);
    assign w_face_acc   = w_s + 3'd1;
    // Only reached for s = 6 or 7, giving faces 1 or 2.
    assign w_face_force = w_s - 3'd5;
    assign w_unused_rnd = ^rnd_in[7:3];

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            r_cyc_cnt <= '0;
            r_rej_cnt <= '0;
            r_face    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_cyc_cnt <= w_cyc_cnt_nxt;
            r_rej_cnt <= w_rej_cnt_nxt;
            r_face    <= w_face_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_cnt_nxt = r_cyc_cnt;
        w_rej_cnt_nxt = r_rej_cnt;
        w_face_nxt    = r_face;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (roll) begin
                    w_state_nxt   = ST_ROLL;
                    w_cyc_cnt_nxt = '0;
                end
            end
            ST_ROLL: begin
                if (w_accept) begin
                    w_face_nxt = w_face_acc;
                end
                w_cyc_cnt_nxt = r_cyc_cnt + 8'd1;
                if (r_cyc_cnt == LP_CYC_LAST) begin
                    w_state_nxt   = ST_SETTLE;
                    w_rej_cnt_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (w_accept) begin
                    w_face_nxt  = w_face_acc;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_rej_cnt == LP_REJ_LAST) begin
                    w_face_nxt  = w_face_force;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rej_cnt_nxt = r_rej_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = r_done;
        face = r_face;
        case (r_face)
            3'd1:    seg = 7'h06;
            3'd2:    seg = 7'h5B;
            3'd3:    seg = 7'h4F;
            3'd4:    seg = 7'h66;
            3'd5:    seg = 7'h6D;
            3'd6:    seg = 7'h7D;
            default: seg = 7'h00;
        endcase
    end

endmodule
